// File: rtl/waterfall_arbiter.sv
// Waterfall pixel RAM arbiter: LCD scan-out reads vs line-writer writes on one port, ring of ROWS+1 lines.
// Latency: read 3 clk (x/y -> ram_addr -> ram_rdata -> vid_data); write issues 1 clk after handshake.
// Backpressure: wr_ready low during visible pixels and after a line commit until the next frame-start edge.
module waterfall_arbiter #(
    parameter int COLS = 320,
    parameter int ROWS = 240,
    parameter int DW   = 8,
    parameter int AW   = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [8:0]    vid_x,
    input  logic [7:0]    vid_y,
    input  logic          vid_visible,
    input  logic          vid_start,
    output logic [DW-1:0] vid_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          line_done,
    output logic          line_err
);
    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS);
    localparam int MW = ((RW > 8) ? RW : 8) + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    logic [RW-1:0] head_q, head_d, head_disp_q, head_disp_d;
    logic [CW-1:0] wr_col_q, wr_col_d;
    logic          done_q, done_d;
    logic          start_q;
    logic          vis1_q, vis2_q;
    logic [DW-1:0] vid_data_q, vid_data_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          line_done_q;
    logic          line_err_q, line_err_d;

    logic [RW-1:0] wr_row, rd_row;
    logic [MW-1:0] hd_m, y_m, rd_wide;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          start_edge, wr_fire, col_end, commit;

    assign wr_row     = (head_q == LAST_ROW) ? '0 : head_q + RW'(1);
    assign start_edge = vid_start & ~start_q;
    assign wr_ready   = ~reset & ~vid_visible & ~done_q;
    assign wr_fire    = wr_valid & wr_ready;
    assign col_end    = (wr_col_q == LAST_COL);
    assign commit     = wr_fire & col_end;

    // Display row counts back from the frame-latched head, wrapping modulo ROWS+1.
    assign hd_m = MW'(head_disp_q);
    assign y_m  = MW'(vid_y);
    always_comb begin
        rd_wide = hd_m - y_m;
        if (hd_m < y_m) begin
            rd_wide = hd_m + MW'(ROWS + 1) - y_m;
        end
    end
    assign rd_row  = RW'(rd_wide);
    assign rd_addr = AW'(rd_row) * AW'(COLS) + AW'(vid_x);
    assign wr_addr = AW'(wr_row) * AW'(COLS) + AW'(wr_col_q);

    always_comb begin
        head_d      = commit ? wr_row : head_q;
        head_disp_d = start_edge ? head_d : head_disp_q;
        done_d      = done_q;
        if (start_edge) begin
            done_d = 1'b0;
        end else if (commit) begin
            done_d = 1'b1;
        end
        wr_col_d = wr_col_q;
        if (wr_fire) begin
            wr_col_d = (col_end || wr_last) ? '0 : wr_col_q + CW'(1);
        end
        line_err_d  = line_err_q | (wr_fire & (col_end ? ~wr_last : wr_last));
        ram_addr_d  = vid_visible ? rd_addr : (wr_fire ? wr_addr : ram_addr_q);
        ram_wdata_d = wr_fire ? wr_data : ram_wdata_q;
        vid_data_d  = vis2_q ? ram_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            head_disp_q <= '0;
            wr_col_q    <= '0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            vis1_q      <= 1'b0;
            vis2_q      <= 1'b0;
            vid_data_q  <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            line_done_q <= 1'b0;
            line_err_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            head_disp_q <= head_disp_d;
            wr_col_q    <= wr_col_d;
            done_q      <= done_d;
            start_q     <= vid_start;
            vis1_q      <= vid_visible;
            vis2_q      <= vis1_q;
            vid_data_q  <= vid_data_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= wr_fire;
            ram_wdata_q <= ram_wdata_d;
            line_done_q <= commit;
            line_err_q  <= line_err_d;
        end
    end

    assign vid_data  = vid_data_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign line_done = line_done_q;
    assign line_err  = line_err_q;
endmodule

// File: tb/tb_waterfall_arbiter.sv
// Bench for waterfall_arbiter: small geometry, line-history reference model, directed and random frames.
module tb_waterfall_arbiter;
    localparam int C  = 16;
    localparam int R  = 6;
    localparam int N  = R + 1;
    localparam int DW = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [8:0]    vid_x;
    logic [7:0]    vid_y;
    logic          vid_visible, vid_start;
    logic [DW-1:0] vid_data;
    logic          wr_valid, wr_ready, wr_last;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          line_done, line_err;

    always #5 clk = ~clk;

    waterfall_arbiter #(.COLS(C), .ROWS(R), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .vid_x(vid_x), .vid_y(vid_y),
        .vid_visible(vid_visible), .vid_start(vid_start), .vid_data(vid_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .line_done(line_done), .line_err(line_err)
    );

    logic [DW-1:0] mem [0:(2**AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: lines are numbered by commit order since reset; line k lives in ring row k mod N.
    int            m_commits, m_hdisp, m_col, m_addr;
    bit            m_done, m_err, m_sprev, e_we, e_done;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] cur [0:C-1];
    logic [DW-1:0] hist [0:511][0:C-1];
    bit            pk [0:2];
    logic [DW-1:0] pd [0:2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_commits = 0; m_hdisp = 0; m_col = 0; m_addr = 0; m_wdata = '0;
        m_done = 0; m_err = 0; m_sprev = 0; e_we = 0; e_done = 0;
        for (int i = 0; i < 3; i++) begin pk[i] = 1; pd[i] = '0; end
    endtask

    task automatic tick();
        bit rdy, hs, edg, rk;
        int idx, row;
        logic [DW-1:0] rv;
        #1;
        rdy = !reset && !vid_visible && !m_done;
        chk("wr_ready", 32'(wr_ready), 32'(rdy));
        @(posedge clk);
        idx = m_hdisp - int'(vid_y);
        row = ((idx % N) + N) % N;
        rk  = !vid_visible || (idx >= 1 && idx <= m_commits);
        rv  = (vid_visible && rk) ? hist[idx][int'(vid_x)] : '0;
        pk[2] = pk[1]; pd[2] = pd[1];
        pk[1] = pk[0]; pd[1] = pd[0];
        pk[0] = rk;    pd[0] = rv;
        if (reset) begin
            model_reset();
        end else begin
            hs = wr_valid && rdy;
            edg = vid_start && !m_sprev;
            e_we = hs;
            e_done = 0;
            if (vid_visible) m_addr = row * C + int'(vid_x);
            else if (hs) begin
                m_addr  = ((m_commits + 1) % N) * C + m_col;
                m_wdata = wr_data;
            end
            if (hs) begin
                cur[m_col] = wr_data;
                if (m_col == C - 1) begin
                    m_commits++;
                    for (int i = 0; i < C; i++) hist[m_commits][i] = cur[i];
                    m_done = 1; e_done = 1;
                    if (!wr_last) m_err = 1;
                    m_col = 0;
                end else if (wr_last) begin
                    m_err = 1; m_col = 0;
                end else m_col++;
            end
            if (edg) begin m_hdisp = m_commits; m_done = 0; end
            m_sprev = vid_start;
        end
        #1;
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
        chk("line_done", 32'(line_done), 32'(e_done));
        chk("line_err", 32'(line_err), 32'(m_err));
        if (pk[2]) chk("vid_data", 32'(vid_data), 32'(pd[2]));
    endtask

    task automatic quiet();
        wr_valid = 0; wr_last = 0; vid_visible = 0; vid_start = 0;
    endtask

    task automatic idle(input int n);
        quiet();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame_start();
        quiet();
        vid_start = 1;
        for (int i = 0; i < 3; i++) tick();
        vid_start = 0;
        tick();
    endtask

    task automatic sample(input logic [DW-1:0] d, input logic last);
        wr_valid = 1; wr_data = d; wr_last = last;
        tick();
        wr_valid = 0; wr_last = 0;
    endtask

    task automatic read_px(input int x, input int y);
        vid_visible = 1; vid_x = 9'(x); vid_y = 8'(y);
        tick();
        vid_visible = 0;
    endtask

    initial begin
        model_reset();
        reset = 1; vid_x = '0; vid_y = '0; wr_data = '0;
        quiet();
        idle(3);
        reset = 0;
        idle(2);

        // Single line into row 1, then display it.
        for (int c = 0; c < C; c++) sample(DW'(c), c == C - 1);
        idle(3);
        frame_start();
        read_px(5, 0);
        idle(4);

        // Visible pixels pre-empt a writer that keeps wr_valid high; line resumes afterwards.
        for (int c = 0; c < 5; c++) sample(DW'(100 + c), 0);
        wr_valid = 1; wr_data = 8'hEE;
        for (int k = 0; k < 4; k++) begin
            vid_visible = 1; vid_x = 9'(k); vid_y = 8'(k % 2);
            tick();
        end
        vid_visible = 0; wr_valid = 0;
        for (int c = 5; c < C; c++) sample(DW'(100 + c), c == C - 1);
        idle(4);

        // Random frames: enough commits to wrap the ring several times.
        for (int f = 0; f < 24; f++) begin
            frame_start();
            for (int t = 0; t < 3 * C; t++) begin
                wr_valid = ($urandom % 4) != 0;
                wr_data  = DW'($urandom);
                wr_last  = (m_col == C - 1) ? (($urandom % 8) != 0) : (($urandom % 64) == 0);
                tick();
            end
            quiet();
            for (int k = 0; k < 2 * C; k++) begin
                vid_visible = ($urandom % 5) != 0 || k < 2;
                vid_x = 9'($urandom % C);
                vid_y = (k < 2) ? 8'(k) : 8'($urandom % R);
                wr_valid = $urandom % 2;
                wr_data = DW'($urandom);
                tick();
            end
            idle(4);
        end

        // Early wr_last on column 3, then a full line without wr_last.
        frame_start();
        for (int c = 0; c < 4; c++) sample(DW'(c), c == 3);
        for (int c = 0; c < C; c++) sample(DW'(50 + c), 0);
        idle(3);

        // Reset in the middle of a line.
        frame_start();
        for (int c = 0; c < 5; c++) sample(DW'(c), 0);
        reset = 1;
        idle(2);
        reset = 0;
        idle(1);
        for (int c = 0; c < C; c++) sample(DW'(200 + c), c == C - 1);
        idle(2);

        // Commit lands on the same cycle as the frame-start edge.
        frame_start();
        for (int c = 0; c < C - 1; c++) sample(DW'(30 + c), 0);
        vid_start = 1;
        sample(DW'(30 + C - 1), 1);
        tick();
        tick();
        vid_start = 0;
        tick();
        read_px(7, 0);
        read_px(3, 1);
        idle(4);

        // Full line without wr_last commits and flags an error.
        for (int c = 0; c < C; c++) sample(DW'(c), 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
